// File: rtl/gate_reduce_pipe.sv
// gate_reduce_pipe: NUM_IN-way bitwise reduction (AND/OR/XOR/NAND) behind a 2-stage valid/ready pipeline.
// Optional feature macro GATE_REDUCE_STATS_EN adds a saturating 16-bit count of completed output transfers.
module gate_reduce_pipe #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned NUM_IN = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [1:0]              in_op,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_ones,
  output logic                    out_zero
`ifdef GATE_REDUCE_STATS_EN
  ,
  output logic [15:0]             out_count
`endif
);

  localparam int unsigned DATA_W = NUM_IN * WIDTH;

  localparam logic [1:0] OP_AND  = 2'b00;
  localparam logic [1:0] OP_OR   = 2'b01;
  localparam logic [1:0] OP_XOR  = 2'b10;
  localparam logic [1:0] OP_NAND = 2'b11;

  logic              s1_valid;
  logic [1:0]        s1_op;
  logic [DATA_W-1:0] s1_data;
  logic              s2_valid;
  logic              s2_load;
  logic              in_fire;

  logic [WIDTH-1:0]  and_acc;
  logic [WIDTH-1:0]  or_acc;
  logic [WIDTH-1:0]  xor_acc;
  logic [WIDTH-1:0]  reduce_c;

  // Handshake: S2 refills when empty or draining; S1 accepts when empty or moving on.
  always_comb begin
    s2_load  = s1_valid && (!s2_valid || out_ready);
    in_ready = !s1_valid || s2_load;
    in_fire  = in_valid && in_ready;
  end

  // NAND inverts the full AND reduction rather than chaining 2-input NANDs.
  always_comb begin
    and_acc = s1_data[WIDTH-1:0];
    or_acc  = s1_data[WIDTH-1:0];
    xor_acc = s1_data[WIDTH-1:0];
    for (int unsigned k = 1; k < NUM_IN; k++) begin
      and_acc = and_acc & s1_data[k*WIDTH +: WIDTH];
      or_acc  = or_acc  | s1_data[k*WIDTH +: WIDTH];
      xor_acc = xor_acc ^ s1_data[k*WIDTH +: WIDTH];
    end
    case (s1_op)
      OP_AND:  reduce_c = and_acc;
      OP_OR:   reduce_c = or_acc;
      OP_XOR:  reduce_c = xor_acc;
      OP_NAND: reduce_c = ~and_acc;
      default: reduce_c = and_acc;
    endcase
  end

  // Stage 1: operand capture.
  always_ff @(posedge clk) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_op    <= 2'b00;
      s1_data  <= '0;
    end else if (in_fire) begin
      s1_valid <= 1'b1;
      s1_op    <= in_op;
      s1_data  <= in_data;
    end else if (s2_load) begin
      s1_valid <= 1'b0;
    end
  end

  // Stage 2: result and flags, driven straight to the outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      s2_valid <= 1'b0;
      out_data <= '0;
      out_ones <= 1'b0;
      out_zero <= 1'b1;
    end else if (s2_load) begin
      s2_valid <= 1'b1;
      out_data <= reduce_c;
      out_ones <= &reduce_c;
      out_zero <= ~|reduce_c;
    end else if (out_ready) begin
      s2_valid <= 1'b0;
    end
  end

  assign out_valid = s2_valid;

`ifdef GATE_REDUCE_STATS_EN
  localparam logic [15:0] COUNT_MAX = 16'hFFFF;

  always_ff @(posedge clk) begin
    if (reset) begin
      out_count <= 16'd0;
    end else if (s2_valid && out_ready && (out_count != COUNT_MAX)) begin
      out_count <= out_count + 16'd1;
    end
  end
`endif

endmodule
